// File: rtl/mmwave_uart_cmd_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : mmwave_uart_cmd_rx_if
//  Brief    : RX serial line plus configuration/status bundle of the command RX
//  Revision : 1.0 - initial release
// ============================================================================
interface mmwave_uart_cmd_rx_if;
    logic        rs232_rx_i;
    logic        vco_mode_o;
    logic [31:0] trigger_freq_psc_o;
    logic [4:0]  chirp_num_o;
    logic [15:0] chirp_freq_psc_o;
    logic [31:0] ad_clk_psc_o;
    logic [15:0] sample_psc_o;
    logic        cfg_update_o;
    logic [7:0]  rx_byte_o;
    logic        rx_byte_valid_o;
    logic        frame_err_o;
    logic        chk_err_o;
    logic        cmd_err_o;

    // Receiver side: consumes the serial line, produces configuration
    modport master (
        input  rs232_rx_i,
        output vco_mode_o, trigger_freq_psc_o, chirp_num_o, chirp_freq_psc_o,
        output ad_clk_psc_o, sample_psc_o, cfg_update_o,
        output rx_byte_o, rx_byte_valid_o, frame_err_o, chk_err_o, cmd_err_o
    );

    // Host/system side: drives the serial line, consumes configuration
    modport slave (
        output rs232_rx_i,
        input  vco_mode_o, trigger_freq_psc_o, chirp_num_o, chirp_freq_psc_o,
        input  ad_clk_psc_o, sample_psc_o, cfg_update_o,
        input  rx_byte_o, rx_byte_valid_o, frame_err_o, chk_err_o, cmd_err_o
    );
endinterface
`default_nettype wire

// File: rtl/mmwave_uart_cmd_rx.sv
`default_nettype none
// ============================================================================
//  Module   : mmwave_uart_cmd_rx
//  Brief    : 8N1 UART receiver and 7-byte command-frame decoder holding the
//             VCO / acquisition configuration registers
//  Revision : 1.0 - initial release
// ============================================================================
module mmwave_uart_cmd_rx #(
    parameter int SYS_CLK_FREQ_MHZ = 50,
    parameter int BAUD_RATE        = 921600,
    parameter int TIMEOUT_CLKS     = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mmwave_uart_cmd_rx_if.master  bus
);

    localparam int c_CLKS_PER_BIT = (SYS_CLK_FREQ_MHZ * 1_000_000) / BAUD_RATE;
    localparam int c_HALF_BIT     = c_CLKS_PER_BIT / 2;
    localparam int c_BIT_CNT_W    = $clog2(c_CLKS_PER_BIT);
    localparam int c_TO_CNT_W     = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [c_BIT_CNT_W-1:0] c_BIT_LAST  = c_BIT_CNT_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_BIT_CNT_W-1:0] c_HALF_LAST = c_BIT_CNT_W'(c_HALF_BIT - 1);
    localparam logic [c_TO_CNT_W-1:0]  c_TO_LAST   = c_TO_CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]             c_HEADER    = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } bit_state_t;

    typedef enum logic [2:0] {
        P_HDR = 3'd0,
        P_CMD = 3'd1,
        P_D3  = 3'd2,
        P_D2  = 3'd3,
        P_D1  = 3'd4,
        P_D0  = 3'd5,
        P_CHK = 3'd6
    } parse_state_t;

    // ------------------------------------------------------------------------
    // Input synchroniser; r_rx_prev gives the falling-edge reference
    // ------------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= bus.rs232_rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // ------------------------------------------------------------------------
    // Bit-level receiver
    // ------------------------------------------------------------------------
    bit_state_t              r_bit_state;
    logic [c_BIT_CNT_W-1:0]  r_bit_clk;
    logic [2:0]              r_bit_idx;
    logic [7:0]              r_shift;
    logic                    r_brk_wait;
    logic [7:0]              r_rx_byte;
    logic                    r_rx_valid;
    logic                    r_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_state <= S_IDLE;
            r_bit_clk   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_brk_wait  <= 1'b0;
            r_rx_byte   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_bit_state)
                S_IDLE: begin
                    r_bit_clk <= '0;
                    if (r_rx_prev && !r_rx_sync)
                        r_bit_state <= S_START;
                end
                S_START: begin
                    if (r_bit_clk == c_HALF_LAST) begin
                        r_bit_clk   <= '0;
                        r_bit_idx   <= '0;
                        // A high line at mid-start-bit is a glitch, not a byte
                        r_bit_state <= r_rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        r_bit_clk <= r_bit_clk + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_bit_clk == c_BIT_LAST) begin
                        r_bit_clk <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7)
                            r_bit_state <= S_STOP;
                    end else begin
                        r_bit_clk <= r_bit_clk + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_brk_wait) begin
                        // Hold off until the line is released after a bad stop bit
                        if (r_rx_sync) begin
                            r_brk_wait  <= 1'b0;
                            r_bit_state <= S_IDLE;
                        end
                    end else if (r_bit_clk == c_BIT_LAST) begin
                        r_bit_clk <= '0;
                        if (r_rx_sync) begin
                            r_rx_byte   <= r_shift;
                            r_rx_valid  <= 1'b1;
                            r_bit_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_brk_wait  <= 1'b1;
                        end
                    end else begin
                        r_bit_clk <= r_bit_clk + 1'b1;
                    end
                end
                default: r_bit_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Frame parser and configuration registers
    // ------------------------------------------------------------------------
    parse_state_t            r_p_state;
    logic [7:0]              r_cmd;
    logic [31:0]             r_value;
    logic [7:0]              r_chk_acc;
    logic [c_TO_CNT_W-1:0]   r_to_cnt;

    logic                    r_vco_mode;
    logic [31:0]             r_trigger_freq_psc;
    logic [4:0]              r_chirp_num;
    logic [15:0]             r_chirp_freq_psc;
    logic [31:0]             r_ad_clk_psc;
    logic [15:0]             r_sample_psc;
    logic                    r_cfg_update;
    logic                    r_chk_err;
    logic                    r_cmd_err;

    logic                    w_val_ok;
    logic                    w_chk_ok;

    always_comb begin
        w_val_ok = 1'b0;
        case (r_cmd)
            8'h01:        w_val_ok = 1'b1;
            8'h02, 8'h05: w_val_ok = (r_value != 32'd0);
            8'h03:        w_val_ok = (r_value[31:5] == '0) && (r_value[4:0] != '0);
            8'h04, 8'h06: w_val_ok = (r_value[31:16] == '0) && (r_value[15:0] != '0);
            default:      w_val_ok = 1'b0;
        endcase
    end

    assign w_chk_ok = (r_rx_byte == r_chk_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_state          <= P_HDR;
            r_cmd              <= '0;
            r_value            <= '0;
            r_chk_acc          <= '0;
            r_to_cnt           <= '0;
            r_vco_mode         <= 1'b1;
            r_trigger_freq_psc <= 32'd2_500_000;
            r_chirp_num        <= 5'd2;
            r_chirp_freq_psc   <= 16'd5;
            r_ad_clk_psc       <= 32'd50;
            r_sample_psc       <= 16'd2;
            r_cfg_update       <= 1'b0;
            r_chk_err          <= 1'b0;
            r_cmd_err          <= 1'b0;
        end else begin
            r_cfg_update <= 1'b0;
            r_chk_err    <= 1'b0;
            r_cmd_err    <= 1'b0;
            if (r_frame_err) begin
                r_p_state <= P_HDR;
                r_to_cnt  <= '0;
            end else if (r_rx_valid) begin
                r_to_cnt <= '0;
                case (r_p_state)
                    P_HDR: if (r_rx_byte == c_HEADER) r_p_state <= P_CMD;
                    P_CMD: begin
                        r_cmd     <= r_rx_byte;
                        r_chk_acc <= r_rx_byte;
                        r_p_state <= P_D3;
                    end
                    P_D3: begin
                        r_value[31:24] <= r_rx_byte;
                        r_chk_acc      <= r_chk_acc ^ r_rx_byte;
                        r_p_state      <= P_D2;
                    end
                    P_D2: begin
                        r_value[23:16] <= r_rx_byte;
                        r_chk_acc      <= r_chk_acc ^ r_rx_byte;
                        r_p_state      <= P_D1;
                    end
                    P_D1: begin
                        r_value[15:8] <= r_rx_byte;
                        r_chk_acc     <= r_chk_acc ^ r_rx_byte;
                        r_p_state     <= P_D0;
                    end
                    P_D0: begin
                        r_value[7:0] <= r_rx_byte;
                        r_chk_acc    <= r_chk_acc ^ r_rx_byte;
                        r_p_state    <= P_CHK;
                    end
                    P_CHK: begin
                        r_p_state <= P_HDR;
                        if (!w_chk_ok) begin
                            r_chk_err <= 1'b1;
                        end else if (!w_val_ok) begin
                            r_cmd_err <= 1'b1;
                        end else begin
                            r_cfg_update <= 1'b1;
                            case (r_cmd)
                                8'h01:   r_vco_mode         <= r_value[0];
                                8'h02:   r_trigger_freq_psc <= r_value;
                                8'h03:   r_chirp_num        <= r_value[4:0];
                                8'h04:   r_chirp_freq_psc   <= r_value[15:0];
                                8'h05:   r_ad_clk_psc       <= r_value;
                                8'h06:   r_sample_psc       <= r_value[15:0];
                                default: ;
                            endcase
                        end
                    end
                    default: r_p_state <= P_HDR;
                endcase
            end else if (r_p_state != P_HDR) begin
                // Inter-byte silence inside a frame abandons it quietly
                if (r_to_cnt == c_TO_LAST) begin
                    r_p_state <= P_HDR;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign bus.vco_mode_o         = r_vco_mode;
    assign bus.trigger_freq_psc_o = r_trigger_freq_psc;
    assign bus.chirp_num_o        = r_chirp_num;
    assign bus.chirp_freq_psc_o   = r_chirp_freq_psc;
    assign bus.ad_clk_psc_o       = r_ad_clk_psc;
    assign bus.sample_psc_o       = r_sample_psc;
    assign bus.cfg_update_o       = r_cfg_update;
    assign bus.rx_byte_o          = r_rx_byte;
    assign bus.rx_byte_valid_o    = r_rx_valid;
    assign bus.frame_err_o        = r_frame_err;
    assign bus.chk_err_o          = r_chk_err;
    assign bus.cmd_err_o          = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_mmwave_uart_cmd_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmwave_uart_cmd_rx
//  Brief    : directed frame stimulus for the UART command receiver
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmwave_uart_cmd_rx;

    localparam int c_CPB     = 54;
    localparam int c_TIMEOUT = 2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    mmwave_uart_cmd_rx_if bus ();

    mmwave_uart_cmd_rx #(
        .SYS_CLK_FREQ_MHZ (50),
        .BAUD_RATE        (921600),
        .TIMEOUT_CLKS     (c_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int n_valid = 0, n_upd = 0, n_chk = 0, n_cmd = 0, n_ferr = 0;
    int last_valid_cyc = 0, upd_delta = -1;
    int s_valid, s_upd, s_chk, s_cmd, s_ferr;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_byte_valid_o) begin
            n_valid        = n_valid + 1;
            last_valid_cyc = cyc;
        end
        if (bus.cfg_update_o) begin
            n_upd     = n_upd + 1;
            upd_delta = cyc - last_valid_cyc;
        end
        if (bus.chk_err_o)   n_chk  = n_chk + 1;
        if (bus.cmd_err_o)   n_cmd  = n_cmd + 1;
        if (bus.frame_err_o) n_ferr = n_ferr + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic snap();
        s_valid = n_valid; s_upd = n_upd; s_chk = n_chk; s_cmd = n_cmd; s_ferr = n_ferr;
    endtask

    task automatic send_bit(input logic v);
        bus.rs232_rx_i = v;
        repeat (c_CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        bus.rs232_rx_i = 1'b1;
    endtask

    task automatic send_frame(input logic [55:0] f);
        for (int i = 6; i >= 0; i--) send_byte(f[i*8 +: 8], 1'b1);
        repeat (10) @(negedge clk);
    endtask

    task automatic check_defaults(input string tag);
        check_val({tag, "_vco"},    32'(bus.vco_mode_o),         32'd1);
        check_val({tag, "_trig"},   bus.trigger_freq_psc_o,      32'd2_500_000);
        check_val({tag, "_chirpn"}, 32'(bus.chirp_num_o),        32'd2);
        check_val({tag, "_chirpf"}, 32'(bus.chirp_freq_psc_o),   32'd5);
        check_val({tag, "_adclk"},  bus.ad_clk_psc_o,            32'd50);
        check_val({tag, "_samp"},   32'(bus.sample_psc_o),       32'd2);
    endtask

    initial begin
        #(20 * 200_000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rs232_rx_i = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);

        check_defaults("rst");
        check_val("rst_rx_byte", 32'(bus.rx_byte_o), 32'd0);
        check_val("rst_pulses", 32'(n_valid + n_upd + n_chk + n_cmd + n_ferr), 32'd0);

        snap();
        send_frame(56'hA5_02_00_4C_4B_40_45);
        check_val("f1_valid_cnt", 32'(n_valid - s_valid), 32'd7);
        check_val("f1_upd_cnt",   32'(n_upd - s_upd),     32'd1);
        check_val("f1_upd_lat",   32'(upd_delta),         32'd1);
        check_val("f1_trig",      bus.trigger_freq_psc_o, 32'd5_000_000);
        check_val("f1_rx_byte",   32'(bus.rx_byte_o),     32'h45);
        check_val("f1_chirpn",    32'(bus.chirp_num_o),   32'd2);
        check_val("f1_adclk",     bus.ad_clk_psc_o,       32'd50);

        snap();
        send_frame(56'hA5_03_00_00_00_04_08);
        check_val("f2_chk_err", 32'(n_chk - s_chk),     32'd1);
        check_val("f2_upd_cnt", 32'(n_upd - s_upd),     32'd0);
        check_val("f2_chirpn",  32'(bus.chirp_num_o),   32'd2);
        snap();
        send_frame(56'hA5_03_00_00_00_04_07);
        check_val("f3_chirpn",  32'(bus.chirp_num_o),   32'd4);
        check_val("f3_upd_cnt", 32'(n_upd - s_upd),     32'd1);

        snap();
        send_frame(56'hA5_07_00_00_00_00_07);
        check_val("f4_cmd_err", 32'(n_cmd - s_cmd),     32'd1);
        send_frame(56'hA5_04_00_00_00_00_04);
        check_val("f5_cmd_err", 32'(n_cmd - s_cmd),     32'd2);
        check_val("f5_chk_err", 32'(n_chk - s_chk),     32'd0);
        check_val("f5_upd_cnt", 32'(n_upd - s_upd),     32'd0);
        check_val("f5_chirpf",  32'(bus.chirp_freq_psc_o), 32'd5);

        snap();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        repeat (c_TIMEOUT + 500) @(negedge clk);
        send_frame(56'hA5_01_00_00_00_00_01);
        check_val("to_vco",      32'(bus.vco_mode_o), 32'd0);
        check_val("to_upd_cnt",  32'(n_upd - s_upd), 32'd1);
        check_val("to_err_cnt",  32'(n_cmd - s_cmd + n_chk - s_chk), 32'd0);
        check_val("to_chirpn",   32'(bus.chirp_num_o), 32'd4);

        snap();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (100) @(negedge clk);
        check_val("fe_ferr_cnt", 32'(n_ferr - s_ferr), 32'd1);
        check_val("fe_valid_cnt", 32'(n_valid - s_valid), 32'd3);
        send_frame(56'hA5_05_00_00_00_64_61);
        check_val("fe_adclk",    bus.ad_clk_psc_o,    32'd100);
        check_val("fe_upd_cnt",  32'(n_upd - s_upd), 32'd1);

        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        bus.rs232_rx_i = 1'b0;
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        bus.rs232_rx_i = 1'b1;
        repeat (3) @(negedge clk);
        check_defaults("mid_rst");
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        snap();
        send_frame(56'hA5_06_00_00_00_03_05);
        check_val("rec_samp",     32'(bus.sample_psc_o), 32'd3);
        check_val("rec_upd_cnt",  32'(n_upd - s_upd),    32'd1);
        check_val("rec_upd_lat",  32'(upd_delta),        32'd1);
        check_val("rec_trig",     bus.trigger_freq_psc_o, 32'd2_500_000);
        check_val("rec_vco",      32'(bus.vco_mode_o),   32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmwave_uart_cmd_rx.md
Name: mmwave_uart_cmd_rx

Overview:
- Host-to-FPGA control path: serial receiver plus command-frame decoder on the rs232 RX line.
- Deserialises 8N1 bytes and parses fixed-length command frames.
- Holds the VCO and acquisition configuration registers, which drive vco_comp_wrapper, ad9226 and dowm_sample in mmwave_system_wrapper.
- Complements the existing sample-upload UART TX path.

Parameters:
- SYS_CLK_FREQ_MHZ, 50, system clock frequency in MHz.
- BAUD_RATE, 921600, serial bit rate. CLKS_PER_BIT = SYS_CLK_FREQ_MHZ*1_000_000/BAUD_RATE, truncated (54 at defaults).
- TIMEOUT_CLKS, 50000, inter-byte timeout inside a frame, in clk cycles (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rs232_rx_i  in  1  serial input, idle high, asynchronous to clk
- vco_mode_o  out  1  VCO mode select
- trigger_freq_psc_o  out  32  VCO trigger prescaler
- chirp_num_o  out  5  chirps per trigger
- chirp_freq_psc_o  out  16  chirp prescaler
- ad_clk_psc_o  out  32  ADC clock prescaler
- sample_psc_o  out  16  down-sample prescaler
- cfg_update_o  out  1  one-cycle pulse when a register is written
- rx_byte_o  out  8  last received byte
- rx_byte_valid_o  out  1  one-cycle pulse per good byte
- frame_err_o  out  1  one-cycle pulse on stop-bit error
- chk_err_o  out  1  one-cycle pulse on checksum mismatch
- cmd_err_o  out  1  one-cycle pulse on unknown command or illegal value

Behaviour:
- Reset values:
  - vco_mode_o=1, trigger_freq_psc_o=2_500_000, chirp_num_o=2, chirp_freq_psc_o=5, ad_clk_psc_o=50, sample_psc_o=2.
  - All pulse outputs 0, rx_byte_o=0.
  - Both FSMs go to idle/header state; reset mid-frame discards the partial frame.
- Input synchroniser: rs232_rx_i passes through a 2-FF synchroniser, reset value 1. All following logic uses the synchronised signal.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synchronised 1->0 edge.
  - START: wait CLKS_PER_BIT/2 cycles (27). If the line is still 0, go to DATA. If 1, treat as a glitch and return to IDLE with no pulse.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Stop bit = 1: on the next clk, rx_byte_o is loaded and rx_byte_valid_o pulses.
    - Stop bit = 0: frame_err_o pulses, byte discarded, IDLE entered only after the line returns high.
- Frame format, 7 bytes: 0xA5, CMD, D3, D2, D1, D0, CHK.
  - Value = {D3,D2,D1,D0}, MSB first.
  - CHK = CMD^D3^D2^D1^D0.
- Parser states: P_HDR, P_CMD, P_D3, P_D2, P_D1, P_D0, P_CHK. Advances one state per rx_byte_valid_o.
  - P_HDR: non-0xA5 bytes are ignored silently.
  - 0xA5 after the header is treated as ordinary data; there is no mid-frame resync.
- Commands and value checks:
  - 0x01 vco_mode = value[0]; any value accepted.
  - 0x02 trigger_freq_psc = value[31:0]; must be nonzero.
  - 0x03 chirp_num = value[4:0]; must be nonzero and value[31:5] must be 0.
  - 0x04 chirp_freq_psc = value[15:0]; must be nonzero and value[31:16] must be 0.
  - 0x05 ad_clk_psc = value[31:0]; must be nonzero.
  - 0x06 sample_psc = value[15:0]; must be nonzero and value[31:16] must be 0.
- On the CHK byte, evaluated in the cycle rx_byte_valid_o is high:
  - Checksum mismatch: chk_err_o pulses next cycle, no write.
  - Checksum OK but unknown CMD or illegal value: cmd_err_o pulses next cycle, no write.
  - Otherwise: target register and cfg_update_o update on the same edge, one cycle after rx_byte_valid_o.
  - The parser returns to P_HDR in all three cases.
- Timeout: a cycle counter runs whenever the parser is not in P_HDR and clears on each rx_byte_valid_o.
  - Reaching TIMEOUT_CLKS returns the parser to P_HDR, no pulse, no write.
- Frame errors mid-frame abort the frame and return the parser to P_HDR.
- Only one register is written per frame; registers are otherwise held indefinitely.
- Back-to-back frames with zero idle gap are supported.

Test Plan:
- Reset, line held high 1 ms -> outputs equal reset defaults; no pulses.
- Send A5 02 00 4C 4B 40 45 at 921600 baud -> 7 rx_byte_valid_o pulses; trigger_freq_psc_o=5_000_000 and cfg_update_o pulse 1 clk after the final rx_byte_valid_o; other registers unchanged.
- Send A5 03 00 00 00 04 08 (bad CHK) -> chk_err_o pulse, chirp_num_o stays 2. Then A5 03 00 00 00 04 07 -> chirp_num_o=4.
- Send A5 07 00 00 00 00 07 -> cmd_err_o. Then A5 04 00 00 00 00 04 (zero value) -> cmd_err_o; chirp_freq_psc_o stays 5.
- Send A5 03, idle 1.2 ms, then A5 01 00 00 00 00 01 -> no update from the partial frame; vco_mode_o=0 with one cfg_update_o.
- Inject a byte with stop bit 0 in the middle of a frame -> frame_err_o, frame discarded; next valid frame is accepted. Assert rst_n low mid-byte -> defaults restored, parser recovers on the next frame.
